// File: rtl/mio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mio_pkg : shared state encodings, size codes and defaults for mio_bridge |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_DONE   = 3'd2,
      ST_ERR    = 3'd3,
      ST_RSVD   = 3'd4
   } mio_state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam int DATA_W          = 32;
   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_TIMEOUT_CYC = 16;

   // Reserved size or an offset that does not fit the natural alignment
   function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
      return (size == SZ_RSVD)
          || (size == SZ_HALF && off[0])
          || (size == SZ_WORD && off != 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mio_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mio_lane_align : byte-enable generation, write lane shift and read       |
// |                  extract/extend for the 4-lane MIO bus (combinational)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mio_lane_align
   import mio_pkg::*;
(
   input  logic [1:0]        i_size,
   input  logic              i_uns,
   input  logic [1:0]        i_off,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_rword,
   output logic [3:0]        o_be,
   output logic [DATA_W-1:0] o_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [4:0]        w_shamt;
   logic [DATA_W-1:0] w_rsh;

   assign w_shamt = {i_off, 3'b000};
   assign w_rsh   = i_rword >> w_shamt;
   assign o_wdata = i_wdata << w_shamt;

   always_comb begin
      o_be    = 4'b1111;
      o_rdata = w_rsh;
      case (i_size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_off;
            o_rdata = {{24{~i_uns & w_rsh[7]}}, w_rsh[7:0]};
         end
         SZ_HALF: begin
            o_be    = 4'b0011 << i_off;
            o_rdata = {{16{~i_uns & w_rsh[15]}}, w_rsh[15:0]};
         end
         default: begin
            o_be    = 4'b1111;
            o_rdata = w_rsh;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mio_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mio_bridge : CPU-to-MIO bus bridge with alignment checks and lane steering|
// | Optional bus wait timeout enabled by defining MIO_TIMEOUT_EN.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mio_bridge
   import mio_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              err,
   input  logic              MIO_ready,
   input  logic [DATA_W-1:0] Data_in,
   output logic [ADDR_W-1:0] Addr_out,
   output logic [DATA_W-1:0] Data_out,
   output logic [3:0]        be,
   output logic              mem_w,
   output logic              CPU_MIO,
   output logic [2:0]        state
);

   if (ADDR_W < 8 || ADDR_W > 32 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_param_check
      $error("mio_bridge: parameter out of supported range");
   end

   mio_state_t        r_state;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_cap;
   logic              r_cpu_mio;
   logic              r_mem_w;
   logic              r_done;
   logic              r_err;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wshift;
   logic [DATA_W-1:0] w_rext;

`ifdef MIO_TIMEOUT_EN
   localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYC - 1);
   logic [7:0] r_wait_cnt;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_we      <= 1'b0;
         r_size    <= 2'b00;
         r_uns     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_cap     <= '0;
         r_cpu_mio <= 1'b0;
         r_mem_w   <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
`ifdef MIO_TIMEOUT_EN
         r_wait_cnt <= 8'd0;
`endif
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
`ifdef MIO_TIMEOUT_EN
               r_wait_cnt <= 8'd0;
`endif
               if (req) begin
                  r_we    <= we;
                  r_size  <= size;
                  r_uns   <= uns;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  if (access_bad(size, addr[1:0])) begin
                     r_state <= ST_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state   <= ST_ACCESS;
                     r_cpu_mio <= 1'b1;
                     r_mem_w   <= we;
                  end
               end
            end
            ST_ACCESS: begin
               // A ready in the final wait cycle takes priority over the timeout
               if (MIO_ready) begin
                  r_cap     <= Data_in;
                  r_state   <= ST_DONE;
                  r_done    <= 1'b1;
                  r_cpu_mio <= 1'b0;
                  r_mem_w   <= 1'b0;
               end
`ifdef MIO_TIMEOUT_EN
               else if (r_wait_cnt == c_wait_last) begin
                  r_state   <= ST_ERR;
                  r_err     <= 1'b1;
                  r_cpu_mio <= 1'b0;
                  r_mem_w   <= 1'b0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
`endif
            end
            ST_DONE, ST_ERR: r_state <= ST_IDLE;
            default: begin
               r_state   <= ST_IDLE;
               r_cpu_mio <= 1'b0;
               r_mem_w   <= 1'b0;
            end
         endcase
      end
   end

   mio_lane_align u_lane_align (
      .i_size  (r_size),
      .i_uns   (r_uns),
      .i_off   (r_addr[1:0]),
      .i_wdata (r_wdata),
      .i_rword (r_cap),
      .o_be    (w_be),
      .o_wdata (w_wshift),
      .o_rdata (w_rext)
   );

   // Bus-side data path is qualified by the registered request so it reads 0 outside ACCESS
   assign CPU_MIO  = r_cpu_mio;
   assign mem_w    = r_mem_w;
   assign be       = r_cpu_mio ? w_be : 4'b0000;
   assign Addr_out = r_cpu_mio ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign Data_out = r_cpu_mio ? w_wshift : '0;
   assign done     = r_done;
   assign err      = r_err;
   assign rdata    = (r_done && !r_we) ? w_rext : '0;
   assign state    = r_state;

endmodule
`default_nettype wire

// File: doc/mio_bridge.md
MIO_BRIDGE -- requirements
Module: mio_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: address width in bits; supported range 8 to 32.
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum ACCESS cycles before a bus error; supported range 2 to 255.
REQ-003 The data path SHALL be fixed at 32 bits, organised as 4 byte lanes.
REQ-004 clk  in  1  the single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  1  CPU access request; sampled only in IDLE.
REQ-007 we  in  1  1 = write, 0 = read.
REQ-008 size  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-009 uns  in  1  for reads, 1 = zero-extend, 0 = sign-extend.
REQ-010 addr  in  ADDR_W  byte address.
REQ-011 wdata  in  32  write data, right-aligned.
REQ-012 rdata  out  32  extended read data; valid while done = 1.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 err  out  1  one-cycle pulse on misalignment, reserved size or timeout.
REQ-015 MIO_ready  in  1  bus ready from the memory/IO side.
REQ-016 Data_in  in  32  bus read data.
REQ-017 Addr_out  out  ADDR_W  bus address, word-aligned (addr[1:0] forced to 00).
REQ-018 Data_out  out  32  write data replicated or shifted onto the selected lanes.
REQ-019 be  out  4  byte enables for the access.
REQ-020 mem_w  out  1  bus write strobe.
REQ-021 CPU_MIO  out  1  bus request, asserted while in ACCESS.
REQ-022 state  out  3  debug encoding of the current FSM state.

Function
REQ-023 The FSM SHALL have five states with fixed encodings: IDLE = 0, ACCESS = 1, DONE = 2, ERR = 3, and code 4 (reserved).
REQ-024 In IDLE with req = 1, the block SHALL latch we, size, uns, addr and wdata.
REQ-025 From IDLE with req = 1, the FSM SHALL go to ERR if size = 11, if size = 01 and addr[0] = 1, or if size = 10 and addr[1:0] != 00; otherwise it SHALL go to ACCESS.
REQ-026 While in ACCESS, the block SHALL drive CPU_MIO = 1, mem_w = latched we, Addr_out, be and Data_out from the latched values only.
REQ-027 Byte enables SHALL be: byte access = 0001 << addr[1:0]; halfword access = 0011 << addr[1:0]; word access = 1111.
REQ-028 Data_out SHALL be latched wdata shifted left by 8*addr[1:0]; lanes outside be are don't-care.
REQ-029 In ACCESS with MIO_ready = 1, the block SHALL capture Data_in into an internal register and go to DONE.
REQ-030 rdata SHALL be the captured word shifted right by 8*addr[1:0], truncated to the access size and extended according to uns; for writes, rdata SHALL be 0.
REQ-031 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-032 In ERR, err SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-033 A req arriving while the block is in DONE or ERR SHALL be ignored.
REQ-034 Minimum latency SHALL be 2 cycles: req in cycle 0, ACCESS in cycle 1 with MIO_ready = 1, done in cycle 2.
REQ-035 Outside ACCESS, CPU_MIO, mem_w and be SHALL be 0.
REQ-036 An unreachable state encoding SHALL return the FSM to IDLE on the next clock.

Reset
REQ-037 While reset = 1, the FSM SHALL enter IDLE on the next edge, and the timeout counter and the capture register SHALL be cleared.
REQ-038 While reset = 1, all outputs SHALL be 0 on the next edge, including Addr_out, Data_out and rdata.
REQ-039 Reset asserted during ACCESS SHALL abort the access with no done or err pulse.

Configuration
REQ-040 Macro MIO_TIMEOUT_EN, when defined, SHALL enable an 8-bit wait counter that clears on entry to ACCESS and increments on each ACCESS cycle with MIO_ready = 0.
REQ-041 With MIO_TIMEOUT_EN defined, an ACCESS cycle with MIO_ready = 0 and counter = TIMEOUT_CYC-1 SHALL transition to ERR; MIO_ready = 1 in that same cycle SHALL win and go to DONE.
REQ-042 Without MIO_TIMEOUT_EN, no wait counter SHALL exist and ACCESS SHALL wait indefinitely for MIO_ready.

Structure
REQ-043 A shared package mio_pkg SHALL hold the state encodings, the size codes and the default parameter constants.
REQ-044 One sub-module, mio_lane_align, SHALL implement be generation, the write shift and the read extract/extend combinationally; the FSM and registers SHALL remain in mio_bridge.

Verification
REQ-045 Word read: addr = 0x100, size = 10, MIO_ready = 1 in the first ACCESS cycle, Data_in = 0xDEADBEEF -> Addr_out = 0x100, be = 1111, done in cycle 2, rdata = 0xDEADBEEF.
REQ-046 Signed byte read: addr = 0x103, size = 00, uns = 0, Data_in = 0x80FFFFFF -> be = 1000, rdata = 0xFFFFFF80; repeated with uns = 1 -> rdata = 0x00000080.
REQ-047 Halfword write: addr = 0x22, wdata = 0x0000ABCD -> Addr_out = 0x20, be = 1100, Data_out[31:16] = 0xABCD, mem_w = 1 only in ACCESS.
REQ-048 Misaligned access: size = 10 with addr = 0x5 -> err pulse in cycle 1, CPU_MIO never asserted; size = 11 -> err pulse as well.
REQ-049 Timeout (macro defined, TIMEOUT_CYC = 4): MIO_ready held at 0 -> err after 4 ACCESS cycles; MIO_ready = 1 on the 4th cycle -> done and no err.
REQ-050 Reset mid-ACCESS: reset asserted in the 2nd wait cycle -> IDLE with all outputs 0 on the next edge; a following word read completes normally.
